// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default bit-period divider settings and frame geometry.
package uart_tx_fifo_pkg;

    // Transmitter FSM states. PARITY is only reachable when the parity
    // option is compiled in; the encoding is fixed either way.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Default divider: bit period is DEF_DIV_CNT+1 clocks, the same
    // convention used by the receive path.
    localparam int         DEF_DIV_WID = 7;
    localparam logic [6:0] DEF_DIV_CNT = 7'd86;

    // Data bits per frame, sent LSB first.
    localparam int FRAME_DATA_BITS = 8;

    // Even parity over one data byte.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Depth is 2**AW. Pushes while full are dropped, pops while empty are
// ignored; a simultaneous accepted push and pop leaves the count alone.
// Read data is presented combinationally from the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come straight from the registered count, so a push on
    // the edge where a pop frees a slot is still refused.
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at 2**AW; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter (8N1, LSB first) with a small transmit FIFO.
// Bytes are pushed with i_dataen while o_ready is high and are sent
// back-to-back: when a stop bit ends with data queued, the next start bit
// follows immediately.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11 bit periods per frame).
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int                 DIV_WID = DEF_DIV_WID,
    parameter logic [DIV_WID-1:0] DIV_CNT = DIV_WID'(DEF_DIV_CNT),
    parameter int                 FIFO_AW = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_data,
    input  logic             i_dataen,
    output logic             o_ready,
    output logic             o_uart_tx,
    output logic             o_busy,
    output logic [FIFO_AW:0] o_fifo_cnt
);

    localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    tx_state_t          state;
    logic [DIV_WID-1:0] div;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               tx;
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    logic               fifo_pop;
    logic [7:0]         fifo_dout;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               bit_end;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (i_dataen),
        .pop   (fifo_pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end    = (div == '0);
    assign o_ready    = ~fifo_full;
    assign o_fifo_cnt = fifo_cnt;
    assign o_uart_tx  = tx;
    assign o_busy     = (state != ST_IDLE) | ~fifo_empty;

    // Pop the FIFO head when idle, or at the end of a stop bit so the next
    // frame starts without an idle gap.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                fifo_pop = 1'b1;
            end else if ((state == ST_STOP) && bit_end) begin
                fifo_pop = 1'b1;
            end
        end
    end

    // Transmit FSM: bit-period divider, shift register and registered line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        shift  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity <= even_parity(fifo_dout);
`endif
                        tx     <= 1'b0;
                        div    <= DIV_CNT;
                        state  <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        div     <= DIV_CNT;
                        state   <= ST_DATA;
                    end else begin
                        div <= div - 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        div <= DIV_CNT;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity;
                            state   <= ST_PARITY;
`else
                            tx      <= 1'b1;
                            state   <= ST_STOP;
`endif
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div <= div - 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        div   <= DIV_CNT;
                        state <= ST_STOP;
                    end else begin
                        div <= div - 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            shift  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                            parity <= even_parity(fifo_dout);
`endif
                            tx     <= 1'b0;
                            div    <= DIV_CNT;
                            state  <= ST_START;
                        end else begin
                            tx    <= 1'b1;
                            div   <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        div <= div - 1'b1;
                    end
                end

                default: begin
                    tx      <= 1'b1;
                    div     <= '0;
                    bit_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with an 8-clock bit period.
// A frame-level reference model (byte queue plus position in the current
// frame) predicts line, busy, count and ready every cycle; a behavioural
// receiver decodes the line and its bytes are compared with what was sent.
module tb_uart_tx_fifo;

    localparam int BIT_CLKS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * BIT_CLKS;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_dataen;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_uart_tx;
    logic       o_busy;
    logic [2:0] o_fifo_cnt;

    uart_tx_fifo #(
        .DIV_WID (7),
        .DIV_CNT (7'd7),
        .FIFO_AW (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_dataen   (i_dataen),
        .o_ready    (o_ready),
        .o_uart_tx  (o_uart_tx),
        .o_busy     (o_busy),
        .o_fifo_cnt (o_fifo_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: queued bytes, byte on the line, position in frame.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur;
    bit         m_in;
    int         m_pos;

    logic [7:0] rx_q[$];

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic [2:0] cnt;
        logic       rdy;
        logic       tx;
        logic       busy;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic exp_line();
        int b;
        if (!m_in) return 1'b1;
        b = m_pos / BIT_CLKS;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        if (NBITS == 11 && b == 9) return ^m_cur;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_in  = 0;
        m_pos = 0;
        m_cur = '0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] d);
        int pre;
        bit acc;
        pre = m_q.size();
        acc = en && (pre < 4);
        if (m_in) begin
            if (m_pos == FL - 1) begin
                if (pre > 0) begin
                    m_cur = m_q.pop_front();
                    m_sent.push_back(m_cur);
                    m_pos = 0;
                end else begin
                    m_in = 0;
                end
            end else begin
                m_pos++;
            end
        end else if (pre > 0) begin
            m_cur = m_q.pop_front();
            m_sent.push_back(m_cur);
            m_in  = 1;
            m_pos = 0;
        end
        if (acc) m_q.push_back(d);
    endtask

    task automatic check_model();
        chk("model_tx",    int'(o_uart_tx),  int'(exp_line()));
        chk("model_busy",  int'(o_busy),     int'(m_in || m_q.size() != 0));
        chk("model_cnt",   int'(o_fifo_cnt), m_q.size());
        chk("model_ready", int'(o_ready),    int'(m_q.size() < 4));
    endtask

    task automatic step(input logic en, input logic [7:0] d);
        i_dataen = en;
        i_data   = d;
        @(posedge i_clk);
        cyc++;
        model_edge(en, d);
        #1;
        check_model();
        i_dataen = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((o_busy || m_in || m_q.size() != 0) && g < 3000) begin
            step(1'b0, 8'h00);
            g++;
        end
        if (g >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: busy=%0d after %0d cycles, want 0", o_busy, g);
        end
        repeat (4) step(1'b0, 8'h00);
    endtask

    // Send one byte from idle; compare every line sample with pat (bit k
    // of pat is frame bit k) and check when busy falls.
    task automatic frame_check(input logic [7:0] d, input logic [10:0] pat);
        int errs;
        errs = 0;
        step(1'b1, d);
        for (int k = 0; k < FL; k++) begin
            step(1'b0, 8'h00);
            if (o_uart_tx !== pat[k / BIT_CLKS]) errs++;
        end
        chk("frame_bits", errs, 0);
        chk("frame_busy_last", int'(o_busy), 1);
        step(1'b0, 8'h00);
        chk("frame_busy_drop", int'(o_busy), 0);
    endtask

    task automatic compare_rx(input string name);
        chk({name, "_rx_len"}, rx_q.size(), m_sent.size());
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++) begin
            chk({name, "_rx_byte"}, int'(rx_q[i]), int'(m_sent[i]));
        end
    endtask

    // Behavioural receiver: detect start, sample mid-bit, LSB first.
    initial begin : rx_proc
        logic [7:0] b;
        forever begin
            @(negedge i_clk);
            if (i_rst !== 1'b1 && o_uart_tx === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge i_clk);
                if (o_uart_tx === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (BIT_CLKS) @(negedge i_clk);
                        b[k] = o_uart_tx;
                    end
                    repeat (NBITS - 9) begin
                        repeat (BIT_CLKS) @(negedge i_clk);
                    end
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin : main
        logic [10:0] pat;
        int lows;
        int guard;
        logic [7:0] exp_tbl [5];

        i_rst    = 1'b1;
        i_dataen = 1'b0;
        i_data   = 8'h00;
        model_reset();

        tv[0] = '{1'b1, 8'hA3, 3'd1, 1'b1, 1'b1, 1'b1};
        tv[1] = '{1'b1, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b1};
        tv[2] = '{1'b1, 8'hFF, 3'd2, 1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b1, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1};
        tv[4] = '{1'b1, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1};
        tv[5] = '{1'b1, 8'h77, 3'd4, 1'b0, 1'b0, 1'b1};
        tv[6] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 1'b1};
        exp_tbl[0] = 8'hA3;
        exp_tbl[1] = 8'h0F;
        exp_tbl[2] = 8'hFF;
        exp_tbl[3] = 8'h00;
        exp_tbl[4] = 8'h11;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        chk("reset_tx",    int'(o_uart_tx),  1);
        chk("reset_busy",  int'(o_busy),     0);
        chk("reset_cnt",   int'(o_fifo_cnt), 0);
        chk("reset_ready", int'(o_ready),    1);

        repeat (100) step(1'b0, 8'h00);

        // Single 0x55 frame.
        rx_q.delete();
        m_sent.delete();
`ifdef UART_TX_PARITY_EN
        pat = {1'b1, 1'b0, 8'h55, 1'b0};
`else
        pat = {1'b0, 1'b1, 8'h55, 1'b0};
`endif
        frame_check(8'h55, pat);
        drain();
        chk("rx55_len", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("rx55_byte", int'(rx_q[0]), 8'h55);

`ifdef UART_TX_PARITY_EN
        pat = {1'b1, 1'b1, 8'h07, 1'b0};
        frame_check(8'h07, pat);
        pat = {1'b1, 1'b0, 8'h03, 1'b0};
        frame_check(8'h03, pat);
        drain();
`endif

        // Burst of writes into an empty FIFO, then overflow attempt.
        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 7; i++) begin
            step(tv[i].en, tv[i].d);
            chk("tbl_cnt",   int'(o_fifo_cnt), int'(tv[i].cnt));
            chk("tbl_ready", int'(o_ready),    int'(tv[i].rdy));
            chk("tbl_tx",    int'(o_uart_tx),  int'(tv[i].tx));
            chk("tbl_busy",  int'(o_busy),     int'(tv[i].busy));
        end
        drain();
        chk("tbl_rx_len", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            chk("tbl_rx_byte", int'(rx_q[i]), int'(exp_tbl[i]));
        end
        compare_rx("tbl");

        // Reset during data bit 3 of 0x3C with two more bytes queued.
        step(1'b1, 8'h3C);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h5A);
        guard = 0;
        while (!(m_in && m_pos == 34) && guard < 200) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("rst_reach_bit3", int'(m_in && m_pos == 34), 1);
        chk("rst_pre_cnt", int'(o_fifo_cnt), 2);
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_async_tx",    int'(o_uart_tx),  1);
        chk("rst_async_cnt",   int'(o_fifo_cnt), 0);
        chk("rst_async_busy",  int'(o_busy),     0);
        chk("rst_async_ready", int'(o_ready),    1);
        @(negedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 8'h00);
            if (o_uart_tx !== 1'b1) lows++;
        end
        chk("post_rst_quiet", lows, 0);

        // Randomised traffic against the reference model.
        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, 8'($urandom_range(0, 255)));
        end
        drain();
        compare_rx("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
